proj_fm_ctrl: RTL and testbench

Sequencer for the ping-pong fragment memory (FM) that feeds the minhash datapath.
- Write side: accepts a valid/ready stream of base symbols and fills the FM write buffer.
- Read side: sweeps the signed fragment index across the read buffer and delivers each fragment downstream through a registered valid/ready stage.
- Issues the buffer-swap pulse only when a full write buffer and a finished read sweep coincide, so no symbol is lost and no fragment is emitted twice.

---
 rtl/proj_fm_ctrl_if.sv | 33 +++
 rtl/proj_fm_ctrl.sv | 126 ++++++++++++
 tb/tb_proj_fm_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/proj_fm_ctrl_if.sv
// Stream, FM and fragment-output signals of the fragment-memory sequencer.
// master = sequencer side, slave = upstream/FM/downstream side.
interface proj_fm_ctrl_if #(
  parameter int DATA_BITS         = 2,
  parameter int FRAG_LEN          = 4,
  parameter int SIGNED_INDICE_LEN = 6
);
  logic                                in_valid;
  logic                                in_ready;
  logic        [DATA_BITS-1:0]         in_data;
  logic                                fm_we;
  logic        [DATA_BITS-1:0]         fm_wdata;
  logic                                fm_chg_idx;
  logic signed [SIGNED_INDICE_LEN-1:0] fm_frag_idx;
  logic        [FRAG_LEN-1:0]          fm_rdata;
  logic                                out_valid;
  logic                                out_ready;
  logic        [FRAG_LEN-1:0]          out_frag;
  logic signed [SIGNED_INDICE_LEN-1:0] out_pos;
  logic                                out_last;

  modport master (
    input  in_valid, in_data, fm_rdata, out_ready,
    output in_ready, fm_we, fm_wdata, fm_chg_idx, fm_frag_idx,
           out_valid, out_frag, out_pos, out_last
  );

  modport slave (
    output in_valid, in_data, fm_rdata, out_ready,
    input  in_ready, fm_we, fm_wdata, fm_chg_idx, fm_frag_idx,
           out_valid, out_frag, out_pos, out_last
  );
endinterface

// File: rtl/proj_fm_ctrl.sv
// Ping-pong fragment-memory sequencer: fills the write buffer, sweeps the read buffer.
// Define FM_CTRL_PERF_EN to add saturating input/output stall counters.
module proj_fm_ctrl #(
  parameter int BUFFER_SIZE       = 16,
  parameter int DATA_BITS         = 2,
  parameter int FRAG_LEN          = 4,
  parameter int INDICE_LEN        = 5,
  parameter int SIGNED_INDICE_LEN = INDICE_LEN + 1,
  parameter int STRIDE            = 1
) (
  input logic clk,
  input logic rst_n,
  proj_fm_ctrl_if.master bus
`ifdef FM_CTRL_PERF_EN
  ,
  output logic [15:0] perf_in_stall,
  output logic [15:0] perf_out_stall
`endif
);

  localparam int SW = SIGNED_INDICE_LEN;
  localparam int CW = SW + 1;
  localparam logic signed [SW-1:0]         START = SW'(-(FRAG_LEN - 1));
  localparam logic signed [CW-1:0]         END_C = CW'(BUFFER_SIZE - 1);
  localparam logic signed [CW-1:0]         STEP  = CW'(STRIDE);
  localparam logic        [INDICE_LEN-1:0] WLAST = INDICE_LEN'(BUFFER_SIZE - 1);

  typedef enum logic {FILL, FULL} wstate_t;
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} rstate_t;

  wstate_t                 wstate;
  rstate_t                 rstate;
  logic [INDICE_LEN-1:0]   wcnt;
  logic signed [SW-1:0]    ridx;
  logic signed [CW-1:0]    ridx_ext;
  logic signed [CW-1:0]    ridx_nxt;
  logic                    accept;
  logic                    load;
  logic                    swap;
  logic                    last_load;
  logic [DATA_BITS-1:0]    wdata;
  logic [FRAG_LEN-1:0]     frag_p0;
  logic signed [SW-1:0]    pos_p0;
  logic                    last_p0;
  logic                    vld_p0;

  assign wdata           = bus.in_data;
  assign accept          = bus.in_valid && (wstate == FILL);
  assign bus.in_ready    = (wstate == FILL);
  assign bus.fm_we       = accept;
  assign bus.fm_wdata    = wdata;

  // A swap needs a full write buffer and a read side that is not mid-sweep.
  assign swap            = (wstate == FULL) && (rstate != SWEEP);
  assign bus.fm_chg_idx  = swap;
  assign bus.fm_frag_idx = ridx;

  // One extra bit so ridx+STRIDE cannot wrap before the signed end test.
  assign ridx_ext  = {ridx[SW-1], ridx};
  assign ridx_nxt  = ridx_ext + STEP;
  assign last_load = (ridx_nxt > END_C);
  assign load      = (rstate == SWEEP) && (!vld_p0 || bus.out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wstate <= FILL;
      wcnt   <= '0;
    end else if (swap) begin
      wstate <= FILL;
      wcnt   <= '0;
    end else if (accept) begin
      wcnt <= wcnt + 1'b1;
      if (wcnt == WLAST) wstate <= FULL;
    end
  end

  // Stage p0: FM fragment captured into the output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rstate  <= IDLE;
      ridx    <= START;
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      frag_p0 <= '0;
      pos_p0  <= '0;
    end else begin
      if (swap) begin
        rstate <= SWEEP;
        ridx   <= START;
      end else if (load) begin
        ridx <= ridx_nxt[SW-1:0];
        if (last_load) rstate <= DONE;
      end
      if (load) begin
        frag_p0 <= bus.fm_rdata;
        pos_p0  <= ridx;
        last_p0 <= last_load;
        vld_p0  <= 1'b1;
      end else if (bus.out_ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign bus.out_valid = vld_p0;
  assign bus.out_frag  = frag_p0;
  assign bus.out_pos   = pos_p0;
  assign bus.out_last  = last_p0;

`ifdef FM_CTRL_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_in_stall  <= '0;
      perf_out_stall <= '0;
    end else begin
      if (bus.in_valid && (wstate != FILL)) perf_in_stall <= sat_inc(perf_in_stall);
      if (vld_p0 && !bus.out_ready) perf_out_stall <= sat_inc(perf_out_stall);
    end
  end
`endif

endmodule

// File: tb/tb_proj_fm_ctrl.sv
// Scoreboard bench for proj_fm_ctrl: instance 0 uses STRIDE=1, instance 1 uses STRIDE=4.
// Each instance has its own FM model, scoreboard queue and output monitor.
module tb_proj_fm_ctrl;

  typedef struct packed {
    logic [3:0]        frag;
    logic signed [5:0] pos;
    logic              last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sbq [2][$];

  logic       drv_valid [2];
  logic [1:0] drv_data  [2];
  logic       drv_ready [2];
  logic       rdy       [2];

  localparam logic [31:0] SYM_A = 32'h1B6C_E4D2;
  localparam logic [31:0] SYM_B = 32'hF0A5_3C96;
  localparam logic [31:0] SYM_C = 32'h7E81_24DB;
  localparam logic [31:0] SYM_J = 32'h0000_03FF;
  localparam logic [31:0] SYM_D = 32'hC3A9_5F06;
  localparam logic [31:0] SYM_E = 32'h9D2E_47B8;

  proj_fm_ctrl_if #(.DATA_BITS(2), .FRAG_LEN(4), .SIGNED_INDICE_LEN(6)) bus [2] ();

  // Fragment at index i is {sym[i], sym[i+1]}; symbols outside the buffer read as 0.
  function automatic logic [3:0] frag_of(input logic [31:0] b, input int i);
    logic [3:0] r;
    r = 4'h0;
    if (i >= 0 && i < 16) r[3:2] = b[2*i +: 2];
    if (i + 1 >= 0 && i + 1 < 16) r[1:0] = b[2*(i+1) +: 2];
    return r;
  endfunction

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0d, required %0d", nm, act, req);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: cycle budget expired", nm);
  endtask

  for (genvar g = 0; g < 2; g++) begin : gm
    logic [31:0] wbuf;
    logic [31:0] rbuf;
    int          wptr;
    int          acc_cnt = 0;
    int          chg_cnt = 0;
`ifdef FM_CTRL_PERF_EN
    logic [15:0] pin;
    logic [15:0] pout;
`endif

    proj_fm_ctrl #(
      .BUFFER_SIZE(16), .DATA_BITS(2), .FRAG_LEN(4), .INDICE_LEN(5),
      .SIGNED_INDICE_LEN(6), .STRIDE(g == 0 ? 1 : 4)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus[g])
`ifdef FM_CTRL_PERF_EN
      ,
      .perf_in_stall(pin),
      .perf_out_stall(pout)
`endif
    );

    assign bus[g].in_valid  = drv_valid[g];
    assign bus[g].in_data   = drv_data[g];
    assign bus[g].out_ready = drv_ready[g];
    assign bus[g].fm_rdata  = frag_of(rbuf, int'($signed(bus[g].fm_frag_idx)));
    assign rdy[g]           = bus[g].in_ready;

    // FM model: write pointer restarts on reset and on every swap.
    always @(posedge clk) begin
      if (!rst_n) begin
        wptr <= 0;
      end else if (bus[g].fm_chg_idx) begin
        rbuf <= wbuf;
        wptr <= 0;
      end else if (bus[g].fm_we) begin
        wbuf[2*wptr[3:0] +: 2] <= bus[g].fm_wdata;
        wptr <= wptr + 1;
      end
    end

    initial begin
      exp_t e;
      logic prev_chg;
      prev_chg = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          prev_chg = 1'b0;
        end else begin
          if (bus[g].in_valid && bus[g].in_ready) acc_cnt++;
          if (bus[g].fm_chg_idx) begin
            chk($sformatf("swap_single_cycle%0d", g), 32'(prev_chg), 0);
            chg_cnt++;
          end
          prev_chg = bus[g].fm_chg_idx;
          if (bus[g].out_valid) begin
            if (sbq[g].size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected_frag%0d: actual pos %0d, required no fragment",
                       g, $signed(bus[g].out_pos));
            end else begin
              e = sbq[g][0];
              chk($sformatf("out_pos%0d", g), $signed(bus[g].out_pos), $signed(e.pos));
              chk($sformatf("out_frag%0d", g), 32'(bus[g].out_frag), 32'(e.frag));
              chk($sformatf("out_last%0d", g), 32'(bus[g].out_last), 32'(e.last));
              if (bus[g].out_ready) void'(sbq[g].pop_front());
            end
          end
        end
      end
    end
  end

  task automatic push_exp(input int d, input logic [31:0] syms);
    exp_t e;
    int stride;
    stride = (d == 0) ? 1 : 4;
    for (int p = -3; p <= 15; p += stride) begin
      e.frag = frag_of(syms, p);
      e.pos  = 6'(p);
      e.last = (p + stride > 15);
      sbq[d].push_back(e);
    end
  endtask

  // Returns one cycle after the last symbol is accepted (posedge + 1).
  task automatic send_syms(input int d, input logic [31:0] syms, input int n, input bit push);
    if (push) push_exp(d, syms);
    for (int i = 0; i < n; i++) begin
      int t;
      t = 0;
      drv_valid[d] = 1'b1;
      drv_data[d]  = syms[2*i +: 2];
      @(negedge clk);
      while (!rdy[d] && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        bound_fail("send_symbol");
        drv_valid[d] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    drv_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d, input string nm);
    int t;
    t = 0;
    while (sbq[d].size() > 0 && t < 400) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk(nm, sbq[d].size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int k;
    bit hit;
    for (int i = 0; i < 2; i++) begin
      drv_valid[i] = 1'b0;
      drv_data[i]  = 2'b00;
      drv_ready[i] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state, idle inputs
    chk("rst_in_ready", 32'(bus[0].in_ready), 1);
    chk("rst_out_valid", 32'(bus[0].out_valid), 0);
    chk("rst_chg_idx", 32'(bus[0].fm_chg_idx), 0);
    chk("rst_frag_idx", $signed(bus[0].fm_frag_idx), -3);
    chk("rst_out_last", 32'(bus[0].out_last), 0);
    chk("rst_out_pos", $signed(bus[0].out_pos), 0);
    chk("rst_out_frag", 32'(bus[0].out_frag), 0);
    chk("rst_frag_idx_b", $signed(bus[1].fm_frag_idx), -3);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_out_valid", 32'(bus[0].out_valid), 0);

    // First fill: read side IDLE, so swap follows the 16th symbol directly
    send_syms(0, SYM_A, 16, 1'b1);
    chk("full_in_ready", 32'(bus[0].in_ready), 0);
    chk("first_swap", 32'(bus[0].fm_chg_idx), 1);
    @(posedge clk);
    #1;
    chk("swap_pulse_end", 32'(bus[0].fm_chg_idx), 0);
    chk("refill_in_ready", 32'(bus[0].in_ready), 1);
    chk("sweep_start_idx", $signed(bus[0].fm_frag_idx), -3);

    // Second buffer fills mid-sweep; swap must wait for the pos-15 load
    send_syms(0, SYM_B, 16, 1'b1);
    hit = 1'b0;
    t = 0;
    while (!hit && t < 100) begin
      if (bus[0].fm_chg_idx) begin
        hit = 1'b1;
        chk("swap_after_last_valid", 32'(bus[0].out_valid), 1);
        chk("swap_after_last_pos", $signed(bus[0].out_pos), 15);
        chk("swap_after_last_flag", 32'(bus[0].out_last), 1);
      end else begin
        chk("in_ready_until_swap", 32'(bus[0].in_ready), 0);
        @(posedge clk);
        #1;
        t++;
      end
    end
    if (!hit) bound_fail("second_swap");
    @(posedge clk);
    #1;
    chk("second_sweep_start", $signed(bus[0].fm_frag_idx), -3);
    chk("second_in_ready", 32'(bus[0].in_ready), 1);
    chk("symbols_accepted", gm[0].acc_cnt, 32);

    // Backpressure 1,0,0,1 over the second sweep
    k = 0;
    t = 0;
    while (sbq[0].size() > 0 && t < 400) begin
      drv_ready[0] = ((k % 4) == 0) || ((k % 4) == 3);
      k++;
      @(posedge clk);
      #1;
      t++;
    end
    drv_ready[0] = 1'b1;
    chk("stall_sweep_drained", sbq[0].size(), 0);

    // Mid-sweep reset at pos 6, with a partial next buffer already written
    send_syms(0, SYM_C, 16, 1'b1);
    send_syms(0, SYM_J, 5, 1'b0);
`ifdef FM_CTRL_PERF_EN
    chk("perf_out_nonzero", 32'(gm[0].pout != 16'd0), 1);
`endif
    hit = 1'b0;
    t = 0;
    while (!hit && t < 100) begin
      @(posedge clk);
      #1;
      t++;
      if (bus[0].out_valid && $signed(bus[0].out_pos) == 6) hit = 1'b1;
    end
    if (!hit) bound_fail("reach_pos6");
    rst_n = 1'b0;
    sbq[0].delete();
    @(posedge clk);
    #1;
    chk("mid_rst_in_ready", 32'(bus[0].in_ready), 1);
    chk("mid_rst_out_valid", 32'(bus[0].out_valid), 0);
    chk("mid_rst_out_last", 32'(bus[0].out_last), 0);
    chk("mid_rst_out_pos", $signed(bus[0].out_pos), 0);
    chk("mid_rst_out_frag", 32'(bus[0].out_frag), 0);
    chk("mid_rst_chg_idx", 32'(bus[0].fm_chg_idx), 0);
    chk("mid_rst_frag_idx", $signed(bus[0].fm_frag_idx), -3);
`ifdef FM_CTRL_PERF_EN
    chk("perf_in_rst", 32'(gm[0].pin), 0);
    chk("perf_out_rst", 32'(gm[0].pout), 0);
`endif
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_no_frag", 32'(bus[0].out_valid), 0);
    send_syms(0, SYM_D, 16, 1'b1);
    drain(0, "post_rst_sweep_drained");
    chk("swap_count", gm[0].chg_cnt, 4);

    // STRIDE=4 instance: positions -3,1,5,9,13
    send_syms(1, SYM_E, 16, 1'b1);
    drain(1, "stride4_drained");
    chk("stride4_swap_count", gm[1].chg_cnt, 1);
    chk("stride4_symbols", gm[1].acc_cnt, 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
